// File: rtl/inst_encoder.sv
// RV32 instruction word encoder with a one-deep output register,
// running word-address counter, accept counter and sticky error flag.
module inst_encoder #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_fmt,
  input  logic [6:0]  req_opcode,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [6:0]  req_funct7,
  input  logic [31:0] req_imm,
  input  logic        load_base,
  input  logic [31:0] base_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] inst_count,
  output logic        err_sticky
);

  localparam logic [2:0] FMT_R = 3'd0;
  localparam logic [2:0] FMT_I = 3'd1;
  localparam logic [2:0] FMT_S = 3'd2;
  localparam logic [2:0] FMT_B = 3'd3;
  localparam logic [2:0] FMT_U = 3'd4;
  localparam logic [2:0] FMT_J = 3'd5;

  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;
  logic [31:0] ctr_q, ctr_d;
  logic [15:0] cnt_q, cnt_d;
  logic        sticky_q, sticky_d;

  logic        accept;
  logic [31:0] base;
  logic [31:0] enc_word;
  logic        enc_err;

  logic is_r, is_i, is_s, is_b, is_u, is_j;
  logic fit12, fit13, fit21;
  logic [31:0] imm;

  assign imm  = req_imm;
  assign is_r = (req_fmt == FMT_R);
  assign is_i = (req_fmt == FMT_I);
  assign is_s = (req_fmt == FMT_S);
  assign is_b = (req_fmt == FMT_B);
  assign is_u = (req_fmt == FMT_U);
  assign is_j = (req_fmt == FMT_J);

  // Sign-extension checks: all bits above the field's MSB match it.
  assign fit12 = (&imm[31:11]) | ~(|imm[31:11]);
  assign fit13 = (&imm[31:12]) | ~(|imm[31:12]);
  assign fit21 = (&imm[31:20]) | ~(|imm[31:20]);

  always_comb begin
    enc_word = 32'h0;
    enc_err  = 1'b0;
    unique case (1'b1)
      is_r: begin
        enc_word = {req_funct7, req_rs2, req_rs1,
                    req_funct3, req_rd, req_opcode};
      end
      is_i: begin
        enc_word = {imm[11:0], req_rs1,
                    req_funct3, req_rd, req_opcode};
        enc_err  = ~fit12;
      end
      is_s: begin
        enc_word = {imm[11:5], req_rs2, req_rs1,
                    req_funct3, imm[4:0], req_opcode};
        enc_err  = ~fit12;
      end
      is_b: begin
        enc_word = {imm[12], imm[10:5], req_rs2, req_rs1,
                    req_funct3, imm[4:1], imm[11], req_opcode};
        enc_err  = ~fit13 | imm[0];
      end
      is_u: begin
        enc_word = {imm[31:12], req_rd, req_opcode};
        enc_err  = |imm[11:0];
      end
      is_j: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                    req_rd, req_opcode};
        enc_err  = ~fit21 | imm[0];
      end
      default: begin
        enc_word = 32'h0;
        enc_err  = 1'b1;
      end
    endcase
  end

  assign req_ready = ~valid_q | out_ready;
  assign accept    = req_valid & req_ready;
  assign base      = load_base ? base_addr : ctr_q;

  always_comb begin
    valid_d  = valid_q;
    inst_d   = inst_q;
    addr_d   = addr_q;
    err_d    = err_q;
    ctr_d    = ctr_q;
    cnt_d    = cnt_q;
    sticky_d = sticky_q;
    if (accept) begin
      valid_d  = 1'b1;
      inst_d   = enc_word;
      addr_d   = base;
      err_d    = enc_err;
      ctr_d    = base + 32'd4;
      cnt_d    = (&cnt_q) ? cnt_q : cnt_q + 16'd1;
      sticky_d = sticky_q | enc_err;
    end else begin
      ctr_d = base;
      if (out_ready) valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q  <= 1'b0;
      inst_q   <= 32'h0;
      addr_q   <= RESET_ADDR;
      err_q    <= 1'b0;
      ctr_q    <= RESET_ADDR;
      cnt_q    <= 16'h0;
      sticky_q <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      addr_q   <= addr_d;
      err_q    <= err_d;
      ctr_q    <= ctr_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_inst   = inst_q;
  assign out_addr   = addr_q;
  assign out_err    = err_q;
  assign inst_count = cnt_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed cases plus random
// traffic against a field-arithmetic reference model.
module tb_inst_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [2:0]  req_funct3;
  logic [6:0]  req_funct7;
  logic [31:0] req_imm;
  logic        load_base;
  logic [31:0] base_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        out_err;
  logic [15:0] inst_count;
  logic        err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  logic        m_valid, m_err, m_sticky;
  logic [31:0] m_inst, m_addr, m_ctr;
  int          m_cnt;

  inst_encoder dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_fmt(req_fmt), .req_opcode(req_opcode),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_funct3(req_funct3), .req_funct7(req_funct7),
    .req_imm(req_imm),
    .load_base(load_base), .base_addr(base_addr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .inst_count(inst_count), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // (v >> lo) mod 2^w
  function automatic longint fld(input longint v, input int lo,
                                 input int w);
    return (v / (64'sd1 << lo)) % (64'sd1 << w);
  endfunction

  function automatic logic [31:0] ref_word();
    longint u, w;
    u = longint'(req_imm);
    w = 0;
    case (req_fmt)
      3'd0: w = req_funct7 * 2**25 + req_rs2 * 2**20
              + req_rs1 * 2**15 + req_funct3 * 2**12
              + req_rd * 2**7 + req_opcode;
      3'd1: w = fld(u, 0, 12) * 2**20 + req_rs1 * 2**15
              + req_funct3 * 2**12 + req_rd * 2**7 + req_opcode;
      3'd2: w = fld(u, 5, 7) * 2**25 + req_rs2 * 2**20
              + req_rs1 * 2**15 + req_funct3 * 2**12
              + fld(u, 0, 5) * 2**7 + req_opcode;
      3'd3: w = fld(u, 12, 1) * 2**31 + fld(u, 5, 6) * 2**25
              + req_rs2 * 2**20 + req_rs1 * 2**15
              + req_funct3 * 2**12 + fld(u, 1, 4) * 2**8
              + fld(u, 11, 1) * 2**7 + req_opcode;
      3'd4: w = fld(u, 12, 20) * 2**12 + req_rd * 2**7 + req_opcode;
      3'd5: w = fld(u, 20, 1) * 2**31 + fld(u, 1, 10) * 2**21
              + fld(u, 11, 1) * 2**20 + fld(u, 12, 8) * 2**12
              + req_rd * 2**7 + req_opcode;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic logic ref_err();
    longint s;
    s = longint'($signed(req_imm));
    case (req_fmt)
      3'd0: return 1'b0;
      3'd1, 3'd2: return (s < -2048) || (s > 2047);
      3'd3: return (s < -4096) || (s > 4094) || (s % 2 != 0);
      3'd4: return (s % 4096) != 0;
      3'd5: return (s < -1048576) || (s > 1048574) || (s % 2 != 0);
      default: return 1'b1;
    endcase
  endfunction

  task automatic step();
    logic        n_valid, n_err, n_sticky, acc;
    logic [31:0] n_inst, n_addr, n_ctr, b;
    int          n_cnt;
    n_valid = m_valid; n_err = m_err; n_sticky = m_sticky;
    n_inst = m_inst; n_addr = m_addr; n_ctr = m_ctr; n_cnt = m_cnt;
    if (reset) begin
      n_valid = 0; n_err = 0; n_sticky = 0; n_inst = 0;
      n_addr = 0; n_ctr = 0; n_cnt = 0;
    end else begin
      acc = req_valid && (!m_valid || out_ready);
      b   = load_base ? base_addr : m_ctr;
      if (acc) begin
        n_valid  = 1;
        n_inst   = ref_word();
        n_err    = ref_err();
        n_addr   = b;
        n_ctr    = b + 32'd4;
        n_cnt    = (m_cnt < 65535) ? m_cnt + 1 : 65535;
        n_sticky = m_sticky | n_err;
      end else begin
        if (load_base) n_ctr = base_addr;
        if (out_ready) n_valid = 0;
      end
    end
    @(posedge clk);
    #1;
    m_valid = n_valid; m_err = n_err; m_sticky = n_sticky;
    m_inst = n_inst; m_addr = n_addr; m_ctr = n_ctr; m_cnt = n_cnt;
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("req_ready", 32'(req_ready), 32'(!m_valid || out_ready));
    chk("out_inst", out_inst, m_inst);
    chk("out_addr", out_addr, m_addr);
    chk("out_err", 32'(out_err), 32'(m_err));
    chk("inst_count", 32'(inst_count), 32'(m_cnt));
    chk("err_sticky", 32'(err_sticky), 32'(m_sticky));
  endtask

  task automatic set_req(input logic [2:0] f, input logic [6:0] op,
                         input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [2:0] f3,
                         input logic [31:0] im);
    req_fmt = f; req_opcode = op; req_rd = rd; req_rs1 = r1;
    req_rs2 = r2; req_funct3 = f3; req_funct7 = 7'h0; req_imm = im;
  endtask

  function automatic logic [31:0] pick_imm();
    int bnd[14] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095,
                    -4098, 1048574, -1048576, 1048576, 1048575,
                    0, -2};
    case ($urandom % 4)
      0: return 32'(bnd[$urandom % 14]);
      1: return 32'($urandom_range(0, 8191)) - 32'd4096;
      2: return $urandom;
      default: return $urandom << 12;
    endcase
  endfunction

  initial begin
    m_valid = 0; m_err = 0; m_sticky = 0; m_inst = 0;
    m_addr = 0; m_ctr = 0; m_cnt = 0;
    reset = 1; req_valid = 1; out_ready = 0;
    load_base = 0; base_addr = 32'h0;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd5);
    step();
    step();
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_count", 32'(inst_count), 32'd0);

    reset = 0; out_ready = 1;
    step();
    chk("addi_inst", out_inst, 32'h0050_0093);
    chk("addi_addr", out_addr, 32'h0);
    chk("addi_err", 32'(out_err), 32'd0);

    set_req(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd4);
    step();
    chk("beq_inst", out_inst, 32'hFE20_8EE3);
    req_imm = 32'd3;
    step();
    chk("beq_odd_err", 32'(out_err), 32'd1);
    chk("beq_sticky", 32'(err_sticky), 32'd1);

    set_req(3'd1, 7'h73, 5'd0, 5'd0, 5'd0, 3'd0, 32'h302);
    step();
    chk("mret", out_inst, 32'h3020_0073);
    req_imm = 32'h001;
    step();
    chk("ebreak", out_inst, 32'h0010_0073);
    set_req(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
    step();
    chk("jal", out_inst, 32'h0010_00EF);
    set_req(3'd6, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 32'd0);
    step();
    chk("rsvd_inst", out_inst, 32'h0);
    chk("rsvd_err", 32'(out_err), 32'd1);

    // backpressure: first result held while downstream stalls
    reset = 1; step(); reset = 0;
    set_req(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd1);
    out_ready = 0; req_valid = 1;
    step();
    req_imm = 32'd2;
    for (int i = 0; i < 3; i++) step();
    chk("hold_inst", out_inst, 32'h0010_0093);
    chk("hold_ready", 32'(req_ready), 32'd0);
    chk("hold_count", 32'(inst_count), 32'd1);
    out_ready = 1;
    step();
    chk("rel_addr", out_addr, 32'h4);
    chk("rel_inst", out_inst, 32'h0020_0093);

    load_base = 1; base_addr = 32'hFFFF_FFFC;
    step();
    chk("wrap_a0", out_addr, 32'hFFFF_FFFC);
    load_base = 0;
    step();
    chk("wrap_a1", out_addr, 32'h0);

    out_ready = 0;
    step();
    reset = 1;
    step();
    chk("rst_pend_v", 32'(out_valid), 32'd0);
    chk("rst_pend_c", 32'(inst_count), 32'd0);
    reset = 0;

    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom % 200) == 0;
      req_valid = ($urandom % 4) != 0;
      out_ready = ($urandom % 10) < 7;
      load_base = ($urandom % 20) == 0;
      base_addr = ($urandom % 2) ? $urandom : 32'hFFFF_FFF8;
      req_fmt    = 3'($urandom % 8);
      req_opcode = 7'($urandom);
      req_rd     = 5'($urandom);
      req_rs1    = 5'($urandom);
      req_rs2    = 5'($urandom);
      req_funct3 = 3'($urandom);
      req_funct7 = 7'($urandom);
      req_imm    = pick_imm();
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 Parameter RESET_ADDR, default 32'h0000_0000, meaning: value loaded into out_addr at reset.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  encode request present.
REQ-005 req_ready  output  1  encoder can accept a request this cycle.
REQ-006 req_fmt  input  3  format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6-7 reserved.
REQ-007 req_opcode  input  7; req_rd, req_rs1, req_rs2  input  5 each; req_funct3  input  3; req_funct7  input  7: instruction fields.
REQ-008 req_imm  input  32  signed byte-offset/immediate value (U: full 32-bit upper value).
REQ-009 load_base  input  1; base_addr  input  32: reload the address counter.
REQ-010 out_valid  output  1; out_ready  input  1: output handshake.
REQ-011 out_inst  output  32  encoded word; out_addr  output  32  word address; out_err  output  1  request was unencodable.
REQ-012 inst_count  output  16  accepted-request count; err_sticky  output  1  any error since reset.

Function
REQ-013 req_ready SHALL equal (!out_valid || out_ready); request accepted when req_valid && req_ready.
REQ-014 Latency SHALL be one cycle: an accepted request appears on out_* with out_valid=1 at the next edge.
REQ-015 out_inst/out_addr/out_err SHALL hold stable while out_valid && !out_ready.
REQ-016 out_valid SHALL clear on an edge with out_ready=1 and no acceptance; acceptance in the same cycle reloads it (back-to-back, full throughput).
REQ-017 Encoding: opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25] for R; I: imm[11:0] in [31:20]; S: imm[11:5] in [31:25], imm[4:0] in [11:7]; B: imm[12],imm[10:5] in [31:25], imm[4:1],imm[11] in [11:7]; U: imm[31:12] in [31:12]; J: imm[20],imm[10:1],imm[11],imm[19:12] in [31:12]. Fields unused by the format SHALL be ignored.
REQ-018 CSR/system words SHALL be produced via fmt=I (csr address or 0x000/0x001/0x302 in req_imm, zimm in req_rs1).
REQ-019 out_err SHALL be set when: I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or imm[0]=1; J imm outside [-1048576,1048574] or imm[0]=1; U imm[11:0]!=0; fmt reserved.
REQ-020 On error the encoded word SHALL still be emitted using truncated fields; reserved fmt emits 32'h0000_0000.
REQ-021 out_addr for each accepted request SHALL be the counter value; counter then increments by 4, wrapping modulo 2^32.
REQ-022 load_base SHALL set the counter to base_addr; if an acceptance coincides, the accepted request uses base_addr and counter becomes base_addr+4.
REQ-023 inst_count SHALL increment per acceptance, saturating at 16'hFFFF.
REQ-024 err_sticky SHALL set on any acceptance with error; cleared only by reset.

Reset
REQ-025 When reset=1 at an edge: out_valid=0, out_inst=0, out_err=0, out_addr=RESET_ADDR, counter=RESET_ADDR, inst_count=0, err_sticky=0; reset overrides simultaneous acceptance and load_base.
REQ-026 req_ready SHALL read 1 during and immediately after reset (out_valid=0); requests presented in the reset cycle are discarded.

Verification
REQ-027 Reset, then fmt=I, opcode=0x13, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> next cycle out_inst=0x00500093, out_addr=0x0, out_err=0.
REQ-028 fmt=B opcode=0x63 funct3=0 rs1=1 rs2=2 imm=-4 -> out_inst=0xFE208EE3; then imm=3 -> out_err=1, err_sticky=1.
REQ-029 fmt=I opcode=0x73 imm=0x302 -> 0x30200073; imm=0x001 -> 0x00100073; fmt=J opcode=0x6F rd=1 imm=2048 -> 0x001000EF.
REQ-030 out_ready=0 for 3 cycles with req_valid=1 -> first result held, req_ready=0, no count increment; release -> results in order, addresses 0x0,0x4.
REQ-031 load_base=1 base_addr=0xFFFFFFFC with acceptance, then second acceptance -> out_addr 0xFFFFFFFC then 0x00000000.
REQ-032 Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0, inst_count=0 next cycle; pending result lost.
